// File: rtl/serial_word_loader.sv
// Serial-to-parallel front end for a storage register: shifts in one word MSB first,
// writes it with a single strobe and optionally reads it back to confirm it.
module serial_word_loader #(
  parameter int WIDTH        = 16,
  parameter int VERIFY       = 1,
  parameter int READ_LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             sin_valid,
  input  logic             sin_bit,
  output logic             sin_ready,
  output logic             write_enable,
  output logic [WIDTH-1:0] write_data,
  output logic             read_enable,
  input  logic [WIDTH-1:0] read_data,
  output logic             busy,
  output logic             done,
  output logic             error
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SHIFT = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_READ  = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_CHECK = 3'd5;
  localparam logic [2:0] S_FIN   = 3'd6;

  logic [2:0]       state;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] count;
  logic [2:0]       wait_cnt;
  logic [WIDTH-1:0] shreg_nxt;

  // Both flags decode straight from the state register, so they drop with reset.
  assign sin_ready = (state == S_SHIFT);
  assign busy      = (state != S_IDLE);
  assign shreg_nxt = {shreg[WIDTH-2:0], sin_bit};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      shreg        <= '0;
      count        <= '0;
      wait_cnt     <= '0;
      write_enable <= 1'b0;
      write_data   <= '0;
      read_enable  <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      write_enable <= 1'b0;
      read_enable  <= 1'b0;
      done         <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            shreg <= '0;
            count <= '0;
            error <= 1'b0;
            state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          // abort takes priority over a bit offered in the same cycle
          if (abort) begin
            state <= S_IDLE;
          end else if (sin_valid) begin
            shreg <= shreg_nxt;
            count <= count + CNT_W'(1);
            if (count == CNT_W'(WIDTH - 1)) begin
              state        <= S_WRITE;
              write_enable <= 1'b1;
              write_data   <= shreg_nxt;
            end
          end
        end
        S_WRITE: begin
          if (VERIFY != 0) begin
            state       <= S_READ;
            read_enable <= 1'b1;
          end else begin
            state <= S_FIN;
            done  <= 1'b1;
          end
        end
        S_READ: begin
          wait_cnt <= 3'(READ_LATENCY - 1);
          state    <= (READ_LATENCY == 1) ? S_CHECK : S_WAIT;
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt - 3'd1;
          if (wait_cnt == 3'd1) begin
            state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (read_data != shreg) begin
            error <= 1'b1;
          end
          state <= S_FIN;
          done  <= 1'b1;
        end
        S_FIN: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_word_loader.sv
// Scoreboard bench for serial_word_loader: one verifying instance with a modelled
// register (1-cycle read latency) and one non-verifying instance.
module tb_serial_word_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  start, abort, sin_valid, sin_bit;
  wire  [1:0]  sin_ready, we, re, busy, done, error;
  wire  [15:0] wd0, wd1;
  logic [15:0] rd0;
  logic [15:0] rd1 = 16'h0000;
  logic [15:0] mem;
  logic        force_zero = 1'b0;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  typedef struct {
    int          inst;
    logic [15:0] wd;
    logic        err;
    int          done_cyc;
    int          rdy;
  } exp_t;

  exp_t q[$];
  int   rdy_cnt [2];
  logic prev_we0;
  bit   re1_seen = 1'b0;

  serial_word_loader #(.WIDTH(16), .VERIFY(1), .READ_LATENCY(1)) dut_v (
    .clk(clk), .reset(reset), .start(start[0]), .abort(abort[0]),
    .sin_valid(sin_valid[0]), .sin_bit(sin_bit[0]), .sin_ready(sin_ready[0]),
    .write_enable(we[0]), .write_data(wd0), .read_enable(re[0]), .read_data(rd0),
    .busy(busy[0]), .done(done[0]), .error(error[0])
  );

  serial_word_loader #(.WIDTH(16), .VERIFY(0), .READ_LATENCY(1)) dut_n (
    .clk(clk), .reset(reset), .start(start[1]), .abort(abort[1]),
    .sin_valid(sin_valid[1]), .sin_bit(sin_bit[1]), .sin_ready(sin_ready[1]),
    .write_enable(we[1]), .write_data(wd1), .read_enable(re[1]), .read_data(rd1),
    .busy(busy[1]), .done(done[1]), .error(error[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Storage register model; force_zero makes its read port return zeros.
  always @(posedge clk) begin
    if (we[0]) mem <= wd0;
    if (re[0]) rd0 <= force_zero ? 16'h0000 : mem;
  end

  function automatic logic [15:0] wdo(input int i);
    return (i == 0) ? wd0 : wd1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic bad(input string name, input int i);
    n_tests++;
    n_fail++;
    $display("FAIL %s on instance %0d at cycle %0d", name, i, cyc);
  endtask

  // Monitor: pops expectations whenever a DUT presents a write or a done pulse.
  initial begin
    exp_t e;
    rdy_cnt[0] = 0;
    rdy_cnt[1] = 0;
    prev_we0 = 1'b0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!busy[i]) rdy_cnt[i] = 0;
        else if (sin_ready[i]) rdy_cnt[i]++;
        if (we[i]) begin
          if (q.size() == 0 || q[0].inst != i) bad("unexpected_write", i);
          else chk("write_data", 32'(wdo(i)), 32'(q[0].wd));
        end
        if (done[i]) begin
          if (q.size() == 0 || q[0].inst != i) bad("unexpected_done", i);
          else begin
            e = q.pop_front();
            chk("error_at_done", 32'(error[i]), 32'(e.err));
            chk("done_cycle", cyc, e.done_cyc);
            chk("sin_ready_cycles", rdy_cnt[i], e.rdy);
          end
        end
      end
      if (prev_we0 || re[0]) chk("read_after_write", 32'(re[0]), 32'(prev_we0));
      prev_we0 = we[0];
      if (re[1]) re1_seen = 1'b1;
    end
  end

  task automatic run_frame(input int i, input logic [15:0] w, input bit stall, input bit poke,
                           input int abort_at, input logic exp_err, input int lat,
                           input int rdy, input logic [15:0] prev_wd);
    exp_t e;
    @(posedge clk); #1;
    start[i] = 1'b1;
    if (abort_at < 0) begin
      e.inst = i; e.wd = w; e.err = exp_err; e.done_cyc = cyc + lat; e.rdy = rdy;
      q.push_back(e);
    end
    @(posedge clk); #1;
    start[i] = 1'b0;
    chk("error_cleared_after_start", 32'(error[i]), 32'(0));
    for (int b = 0; b < 16; b++) begin
      if (stall) begin
        sin_valid[i] = 1'b0;
        @(posedge clk); #1;
      end
      sin_valid[i] = 1'b1;
      sin_bit[i]   = w[15-b];
      if (b == abort_at) abort[i] = 1'b1;
      if (poke && b == 5) start[i] = 1'b1;
      @(posedge clk); #1;
      sin_valid[i] = 1'b0;
      start[i]     = 1'b0;
      if (b == abort_at) begin
        abort[i] = 1'b0;
        chk("abort_busy", 32'(busy[i]), 32'(0));
        chk("abort_sin_ready", 32'(sin_ready[i]), 32'(0));
        chk("abort_write_data", 32'(wdo(i)), 32'(prev_wd));
        repeat (25) @(posedge clk);
        return;
      end
    end
    if (poke) begin
      start[i] = 1'b1;
      @(posedge clk); #1;
      start[i] = 1'b0;
    end
    for (int k = 0; k < 60 && q.size() > 0; k++) @(posedge clk);
    if (q.size() > 0) begin
      bad("done_timeout", i);
      q.delete();
    end
  endtask

  task automatic chk_zero(input int i, input string tag);
    chk({tag, "_busy"}, 32'(busy[i]), 32'(0));
    chk({tag, "_sin_ready"}, 32'(sin_ready[i]), 32'(0));
    chk({tag, "_write_enable"}, 32'(we[i]), 32'(0));
    chk({tag, "_read_enable"}, 32'(re[i]), 32'(0));
    chk({tag, "_done"}, 32'(done[i]), 32'(0));
    chk({tag, "_error"}, 32'(error[i]), 32'(0));
    chk({tag, "_write_data"}, 32'(wdo(i)), 32'(0));
  endtask

  initial begin
    reset = 1'b0;
    start = '0; abort = '0; sin_valid = '0; sin_bit = '0;
    #3;
    chk_zero(0, "reset");
    chk_zero(1, "reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    run_frame(0, 16'hAAAA, 1'b0, 1'b0, -1, 1'b0, 20, 16, 16'h0000);
    run_frame(0, 16'h1234, 1'b1, 1'b0, -1, 1'b0, 36, 32, 16'h0000);

    force_zero = 1'b1;
    run_frame(0, 16'hFFFF, 1'b0, 1'b0, -1, 1'b1, 20, 16, 16'h0000);
    force_zero = 1'b0;
    @(posedge clk); #1;
    chk("error_sticky_in_idle", 32'(error[0]), 32'(1));

    run_frame(0, 16'h1234, 1'b0, 1'b0, -1, 1'b0, 20, 16, 16'h0000);
    run_frame(0, 16'hBEEF, 1'b0, 1'b0, 7, 1'b0, 0, 0, 16'h1234);

    // Asynchronous reset pulse in the middle of SHIFT.
    @(posedge clk); #1;
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    for (int b = 0; b < 5; b++) begin
      sin_valid[0] = 1'b1;
      sin_bit[0]   = b[0];
      @(posedge clk); #1;
    end
    sin_valid[0] = 1'b0;
    #5 reset = 1'b0;
    #1 chk_zero(0, "async_reset");
    #2 reset = 1'b1;
    run_frame(0, 16'hC3A5, 1'b0, 1'b0, -1, 1'b0, 20, 16, 16'h0000);

    run_frame(1, 16'h00FF, 1'b0, 1'b1, -1, 1'b0, 18, 16, 16'h0000);
    run_frame(1, 16'h8001, 1'b0, 1'b0, -1, 1'b0, 18, 16, 16'h0000);

    repeat (3) @(posedge clk);
    #1;
    chk("no_verify_read_enable", 32'(re1_seen), 32'(0));
    chk("no_verify_write_data_held", 32'(wd1), 32'(16'h8001));
    chk("verify_write_data_held", 32'(wd0), 32'(16'hC3A5));
    chk("scoreboard_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_word_loader.md
Name: serial_word_loader

Overview:
- Upstream feeder for the 16-bit storage register. It accepts a word one bit at a time, MSB first, over a valid/ready handshake.
- Once the word is complete, it issues a single write_enable pulse with the assembled word on write_data.
- It can optionally read the word back from the register to confirm it. A mismatch raises a sticky error flag.
- It connects directly to the register's write_enable, write_data, read_enable and read_data ports.

Parameters:
- WIDTH, 16: word width in bits, and also the number of serial bits per frame.
- VERIFY, 1: 1 enables the read-back check; 0 skips it.
- READ_LATENCY, 1: number of clk cycles from the read_enable pulse until read_data is valid. Legal range 1..4.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a new frame.
- abort  input  1  discards the frame in progress and returns to IDLE.
- sin_valid  input  1  sin_bit is valid this cycle.
- sin_bit  input  1  serial data bit, MSB first.
- sin_ready  output  1  loader will accept a bit this cycle.
- write_enable  output  1  one-cycle write strobe to the register.
- write_data  output  WIDTH  assembled word.
- read_enable  output  1  one-cycle read strobe to the register.
- read_data  input  WIDTH  register read-back value.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when a frame completes.
- error  output  1  sticky read-back mismatch flag.

Behaviour:
- Reset (reset low, asynchronous):
  - state goes to IDLE; shift register and bit count go to 0.
  - sin_ready, write_enable, read_enable, busy, done and error all go to 0; write_data goes to 0.
  - Reset is released synchronously to clk.
- All outputs are registered. sin_ready is decoded from the registered state.
- State IDLE:
  - If start=1: clear shreg and count, clear error, go to SHIFT.
  - sin_valid is ignored.
- State SHIFT:
  - sin_ready=1.
  - On each cycle with sin_valid && sin_ready: shreg <= {shreg[WIDTH-2:0], sin_bit} and count increments.
  - When count is WIDTH-1 and a bit is accepted, go to WRITE on the next edge.
  - Cycles with sin_valid=0 are stalls: count is unchanged and there is no timeout.
- State WRITE:
  - Lasts exactly one cycle; write_enable=1 and write_data=shreg.
  - write_data holds that value after the state exits, until the next WRITE or reset.
  - Next state is READ if VERIFY=1, otherwise FIN.
- State READ:
  - Lasts one cycle; read_enable=1.
  - A wait counter is loaded with READ_LATENCY-1.
  - Next state is WAIT, or CHECK directly if READ_LATENCY=1.
- State WAIT: decrement the wait counter; go to CHECK when it reaches 0.
- State CHECK:
  - Sample read_data and compare it with shreg; if they differ, error <= 1.
  - Next state is FIN.
- State FIN: done=1 for one cycle, then go to IDLE.
- Latency:
  - With VERIFY=0 and no stalls: done is asserted WIDTH+2 cycles after the start cycle.
  - With VERIFY=1 and no stalls: done is asserted WIDTH+3+READ_LATENCY cycles after the start cycle.
- busy=1 in SHIFT, WRITE, READ, WAIT, CHECK and FIN.
- start while busy=1 is ignored, with no effect on the current frame.
- abort:
  - Honoured only in SHIFT: go to IDLE with no write and no done pulse. The partial word is dropped and write_data is unchanged.
  - In all other states abort is ignored, so a write that has been issued always completes.
- abort and a bit accepted in the same cycle: abort wins and the bit is dropped.
- start and abort together in IDLE: start wins.
- error:
  - Stays set through IDLE.
  - Is cleared only by an accepted start or by reset.
  - Does not block new frames.
- Reset mid-frame:
  - Takes effect immediately with no clock needed; any in-flight write or read strobe is deasserted.
  - The next frame requires a fresh start.
- count width is clog2(WIDTH)+1.
- No wrap-around: SHIFT exits on the WIDTH-th accepted bit.

Test Plan:
- Reset, then drive start, then 16 bits of 16'hAAAA with no stalls; a model register with 1-cycle read latency.
  -> sin_ready high for exactly 16 cycles; a single write_enable pulse with write_data=16'hAAAA; read_enable one cycle later; done at cycle 20 after start; error=0.
- Same frame 16'h1234 with sin_valid low on every other cycle.
  -> count advances only on valid bits; write_data=16'h1234; done delayed by 16 cycles versus the no-stall case.
- Model register forces read_data=16'h0000 while the frame is 16'hFFFF.
  -> error=1 after CHECK and done pulses. Then start a new frame: error is cleared in the cycle after start.
- abort after 7 bits of 16'hBEEF, with write_data=16'h1234 from a prior frame.
  -> immediate return to IDLE; no write_enable and no done; write_data remains 16'h1234.
- Pull reset low for 3 ns mid-SHIFT, asynchronous to clk.
  -> all outputs go to 0 immediately; asserting start again loads a full clean frame correctly.
- VERIFY=0, frame 16'h00FF.
  -> no read_enable ever; done exactly 18 cycles after start; start pulses while busy are ignored.
